load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns the load/store request held in the EX/MEM register
// into a single-beat data-memory transaction and returns the load result to
// MEM/WB.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ctrl_mem_read_exe_mem       load request (wins if write is also high)
//   ctrl_mem_write_exe_mem      store request
//   funct3_exe_mem              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_out_exe_mem             byte address
//   w_data_exe_mem              store data
//   dmem_req/we/addr/wdata/be   memory request, held until dmem_ready
//   dmem_ready, dmem_rdata      memory completion and read data
//   r_data_mem_wb               aligned, extended load result (held)
//   load_valid_mem_wb           one-cycle pulse when a load completes
//   stall                       freeze upstream stages (combinational)
//   misalign_err, bus_err       one-cycle error pulses
//
// Build option: define LSU_TIMEOUT_EN to abandon a request after 16 REQ
// cycles without dmem_ready (bus_err pulse, zero load result). Without it the
// unit waits indefinitely and bus_err is tied low.
module load_store_unit #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_mem_read_exe_mem,
  input  logic                 ctrl_mem_write_exe_mem,
  input  logic [2:0]           funct3_exe_mem,
  input  logic [DataWidth-1:0] alu_out_exe_mem,
  input  logic [DataWidth-1:0] w_data_exe_mem,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [AddrWidth-1:0] dmem_addr,
  output logic [DataWidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ready,
  input  logic [DataWidth-1:0] dmem_rdata,
  output logic [DataWidth-1:0] r_data_mem_wb,
  output logic                 load_valid_mem_wb,
  output logic                 stall,
  output logic                 misalign_err,
  output logic                 bus_err
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic                is_load_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;

  logic                access;
  logic                is_load;
  logic                misaligned;
  logic                timeout;
  logic [1:0]          off;
  logic [3:0]          be_next;
  logic [DataWidth-1:0] wdata_next;
  logic [DataWidth-1:0] rd_shift;
  logic [DataWidth-1:0] load_ext;

  // Address bits above the data-memory window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^alu_out_exe_mem[DataWidth-1:AddrWidth+2];

  assign off     = alu_out_exe_mem[1:0];
  assign access  = ctrl_mem_read_exe_mem | ctrl_mem_write_exe_mem;
  assign is_load = ctrl_mem_read_exe_mem;

  // Undefined funct3 encodings follow the word rules.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_exe_mem)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = off[0];
      default:        misaligned = (off != 2'b00);
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = w_data_exe_mem;
    if (!is_load) begin
      case (funct3_exe_mem)
        3'b000, 3'b100: begin
          be_next    = 4'b0001 << off;
          wdata_next = DataWidth'({4{w_data_exe_mem[7:0]}});
        end
        3'b001, 3'b101: begin
          be_next    = off[1] ? 4'b1100 : 4'b0011;
          wdata_next = DataWidth'({2{w_data_exe_mem[15:0]}});
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = w_data_exe_mem;
        end
      endcase
    end
  end

  // Aligned halfwords always have off_q[0]=0, so one byte-granular shift
  // serves both byte and halfword loads.
  always_comb begin
    rd_shift = dmem_rdata >> {off_q, 3'b000};
    load_ext = dmem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{(DataWidth-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {{(DataWidth-8){1'b0}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(DataWidth-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_ext = {{(DataWidth-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       bus_err_q;
  assign timeout = (state == REQ) && !dmem_ready && (tmo_cnt == 4'hF);
  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // The abandoning cycle releases the stall just like a completion, so the
  // upstream stage is not left frozen on a request that is no longer active.
  assign stall = (state == IDLE) ? (access && !misaligned)
                                 : !(dmem_ready || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      dmem_be           <= '0;
      r_data_mem_wb     <= '0;
      load_valid_mem_wb <= 1'b0;
      misalign_err      <= 1'b0;
      is_load_q         <= 1'b0;
      f3_q              <= '0;
      off_q             <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt           <= '0;
      bus_err_q         <= 1'b0;
`endif
    end else begin
      load_valid_mem_wb <= 1'b0;
      misalign_err      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err_q         <= 1'b0;
`endif
      if (state == IDLE) begin
        if (access) begin
          if (misaligned) begin
            misalign_err <= 1'b1;
          end else begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= !is_load;
            dmem_addr  <= alu_out_exe_mem[AddrWidth+1:2];
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            is_load_q  <= is_load;
            f3_q       <= funct3_exe_mem;
            off_q      <= off;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end
      end else begin
        if (dmem_ready) begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          if (is_load_q) begin
            r_data_mem_wb     <= load_ext;
            load_valid_mem_wb <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          tmo_cnt <= '0;
        end else if (timeout) begin
          state     <= IDLE;
          dmem_req  <= 1'b0;
          dmem_we   <= 1'b0;
          bus_err_q <= 1'b1;
          tmo_cnt   <= '0;
          if (is_load_q) begin
            r_data_mem_wb     <= '0;
            load_valid_mem_wb <= 1'b1;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 4'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd, wr;
  logic [2:0]    f3;
  logic [DW-1:0] addr, wdata;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [3:0]    dmem_be;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] r_data;
  logic          load_valid, stall, misalign_err, bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ctrl_mem_read_exe_mem  (rd),
    .ctrl_mem_write_exe_mem (wr),
    .funct3_exe_mem         (f3),
    .alu_out_exe_mem        (addr),
    .w_data_exe_mem         (wdata),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_be                (dmem_be),
    .dmem_ready             (dmem_ready),
    .dmem_rdata             (dmem_rdata),
    .r_data_mem_wb          (r_data),
    .load_valid_mem_wb      (load_valid),
    .stall                  (stall),
    .misalign_err           (misalign_err),
    .bus_err                (bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'b000;
    addr = '0; wdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    #2;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, r_data,
         load_valid, misalign_err, bus_err, stall} !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%b we=%b addr=%h wdata=%h be=%b rdata=%h lv=%b mis=%b berr=%b stall=%b, all required 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, r_data,
               load_valid, misalign_err, bus_err, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // LB from byte 3 with one wait cycle: stall high for two cycles.
  task automatic test_lb();
    rd = 1'b1; f3 = 3'b000; addr = 32'h003;
    dmem_rdata = 32'h80FF_1234; dmem_ready = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL lb_stall_accept got=%b exp=1", stall); end
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall} !== {1'b1, 1'b0, 10'd0, 4'b1111, 1'b1}) begin
      failures++;
      $display("FAIL lb_request req=%b we=%b addr=%h be=%b stall=%b exp 1 0 000 1111 1",
               dmem_req, dmem_we, dmem_addr, dmem_be, stall);
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lb_stall_ready got=%b exp=0", stall); end
    tick();
    checks++;
    if ({dmem_req, load_valid, r_data} !== {1'b0, 1'b1, 32'hFFFF_FF80}) begin
      failures++;
      $display("FAIL lb_result req=%b lv=%b rdata=%h exp 0 1 ffffff80", dmem_req, load_valid, r_data);
    end
    rd = 1'b0; dmem_ready = 1'b0;
    tick();
    checks++;
    if ({load_valid, dmem_req, r_data} !== {1'b0, 1'b0, 32'hFFFF_FF80}) begin
      failures++;
      $display("FAIL lb_pulse_hold lv=%b req=%b rdata=%h exp 0 0 ffffff80", load_valid, dmem_req, r_data);
    end
  endtask

  task automatic test_store_sh();
    wr = 1'b1; f3 = 3'b001; addr = 32'h00A; wdata = 32'h0000_BEEF; dmem_ready = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL sh_stall_accept got=%b exp=1", stall); end
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
        {1'b1, 1'b1, 10'd2, 4'b1100, 32'hBEEF_BEEF}) begin
      failures++;
      $display("FAIL sh_request req=%b we=%b addr=%h be=%b wdata=%h exp 1 1 002 1100 beefbeef",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    checks++;
    if ({dmem_req, dmem_we, load_valid, r_data} !== {1'b0, 1'b0, 1'b0, 32'hFFFF_FF80}) begin
      failures++;
      $display("FAIL sh_complete req=%b we=%b lv=%b rdata=%h exp 0 0 0 ffffff80",
               dmem_req, dmem_we, load_valid, r_data);
    end
    wr = 1'b0; dmem_ready = 1'b0;
    tick();
  endtask

  // SB with ready already high: one REQ cycle, then back in IDLE.
  task automatic test_store_sb();
    wr = 1'b1; f3 = 3'b000; addr = 32'h005; wdata = 32'h1234_56A7; dmem_ready = 1'b1;
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !==
        {1'b1, 1'b1, 10'd1, 4'b0010, 32'hA7A7_A7A7, 1'b0}) begin
      failures++;
      $display("FAIL sb_request req=%b we=%b addr=%h be=%b wdata=%h stall=%b exp 1 1 001 0010 a7a7a7a7 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall);
    end
    tick();
    wr = 1'b0; dmem_ready = 1'b0;
    checks++;
    if ({dmem_req, dmem_we} !== 2'b00) begin
      failures++;
      $display("FAIL sb_min_latency req=%b we=%b exp 0 0", dmem_req, dmem_we);
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [2:0]  mf3   [4];
    logic [31:0] maddr [4];
    logic        mwr   [4];
    mf3 = '{3'b010, 3'b001, 3'b010, 3'b110};
    maddr = '{32'h006, 32'h003, 32'h001, 32'h002};
    mwr = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rd = !mwr[i]; wr = mwr[i]; f3 = mf3[i]; addr = maddr[i];
      #1;
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall[%0d] got=%b exp=0", i, stall); end
      tick();
      rd = 1'b0; wr = 1'b0;
      checks++;
      if ({misalign_err, dmem_req} !== 2'b10) begin
        failures++;
        $display("FAIL misalign_pulse[%0d] mis=%b req=%b exp 1 0", i, misalign_err, dmem_req);
      end
      tick();
      checks++;
      if (misalign_err !== 1'b0) begin failures++; $display("FAIL misalign_clear[%0d] got=%b exp=0", i, misalign_err); end
    end
  endtask

  task automatic test_lhu_wait();
    rd = 1'b1; f3 = 3'b101; addr = 32'h002; dmem_rdata = 32'hA5A5_0000; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall} !== {1'b1, 1'b0, 10'd0, 4'b1111, 1'b1}) begin
        failures++;
        $display("FAIL lhu_hold[%0d] req=%b we=%b addr=%h be=%b stall=%b exp 1 0 000 1111 1",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, stall);
      end
    end
    dmem_ready = 1'b1;
    tick();
    rd = 1'b0; dmem_ready = 1'b0;
    checks++;
    if ({load_valid, r_data} !== {1'b1, 32'h0000_A5A5}) begin
      failures++;
      $display("FAIL lhu_result lv=%b rdata=%h exp 1 0000a5a5", load_valid, r_data);
    end
    tick();
  endtask

  task automatic test_load_ext();
    logic [2:0]  lf3 [6];
    logic [31:0] la  [6];
    logic [31:0] lrd [6];
    logic [31:0] lex [6];
    logic        lwr [6];
    lf3 = '{3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
    la  = '{32'h000, 32'h001, 32'h002, 32'h002, 32'h004, 32'h008};
    lrd = '{32'h1234_8001, 32'h0000_9A00, 32'h007F_0000, 32'h8000_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    lex = '{32'hFFFF_8001, 32'h0000_009A, 32'h0000_007F, 32'hFFFF_8000, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    lwr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      rd = 1'b1; wr = lwr[i]; f3 = lf3[i]; addr = la[i]; wdata = 32'h5555_5555;
      dmem_rdata = lrd[i]; dmem_ready = 1'b1;
      tick();
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, la[i][11:2], 4'b1111}) begin
        failures++;
        $display("FAIL ld_request[%0d] req=%b we=%b addr=%h be=%b exp 1 0 %h 1111",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, la[i][11:2]);
      end
      tick();
      rd = 1'b0; wr = 1'b0; dmem_ready = 1'b0;
      checks++;
      if ({load_valid, r_data} !== {1'b1, lex[i]}) begin
        failures++;
        $display("FAIL ld_result[%0d] lv=%b rdata=%h exp 1 %h", i, load_valid, r_data, lex[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_req();
    rd = 1'b1; f3 = 3'b010; addr = 32'h00C; dmem_ready = 1'b0; dmem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (dmem_req !== 1'b1) begin failures++; $display("FAIL rstreq_request got=%b exp=1", dmem_req); end
    #2;
    rst_n = 1'b0; rd = 1'b0;
    #1;
    checks++;
    if ({dmem_req, dmem_addr, dmem_be, stall, r_data} !== '0) begin
      failures++;
      $display("FAIL rstreq_async req=%b addr=%h be=%b stall=%b rdata=%h exp all 0",
               dmem_req, dmem_addr, dmem_be, stall, r_data);
    end
    dmem_ready = 1'b1;
    tick();
    checks++;
    if ({load_valid, dmem_req} !== 2'b00) begin
      failures++;
      $display("FAIL rstreq_no_valid lv=%b req=%b exp 0 0", load_valid, dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b1; dmem_ready = 1'b0;
    tick();
    checks++;
    if ({dmem_req, load_valid, stall} !== 3'b000) begin
      failures++;
      $display("FAIL rstreq_idle req=%b lv=%b stall=%b exp 0 0 0", dmem_req, load_valid, stall);
    end
  endtask

  task automatic test_timeout();
    int seen_berr;
    rd = 1'b1; f3 = 3'b010; addr = 32'h010; dmem_ready = 1'b0; dmem_rdata = 32'h1122_3344;
    tick();
    seen_berr = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (bus_err !== 1'b0 || dmem_req !== 1'b1) seen_berr++;
    end
    checks++;
    if (seen_berr != 0) begin failures++; $display("FAIL tmo_early bad_cycles=%0d exp=0", seen_berr); end
`ifdef LSU_TIMEOUT_EN
    tick();
    rd = 1'b0;
    checks++;
    if ({dmem_req, bus_err, load_valid, r_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL tmo_expire req=%b berr=%b lv=%b rdata=%h exp 0 1 1 0", dmem_req, bus_err, load_valid, r_data);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", bus_err); end
`else
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if ({dmem_req, bus_err, stall, dmem_addr} !== {1'b1, 1'b0, 1'b1, 10'd4}) begin
      failures++;
      $display("FAIL wait_forever req=%b berr=%b stall=%b addr=%h exp 1 0 1 004", dmem_req, bus_err, stall, dmem_addr);
    end
    dmem_ready = 1'b1;
    tick();
    rd = 1'b0; dmem_ready = 1'b0;
    checks++;
    if ({load_valid, r_data, bus_err} !== {1'b1, 32'h1122_3344, 1'b0}) begin
      failures++;
      $display("FAIL wait_complete lv=%b rdata=%h berr=%b exp 1 11223344 0", load_valid, r_data, bus_err);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_lb();
    test_store_sh();
    test_store_sb();
    test_misalign();
    test_lhu_wait();
    test_load_ext();
    test_reset_in_req();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
